mod_mult_pipe: RTL and testbench

- Pipelined, parameterised Barrett modular multiplier: out = (a*b) mod q.
- Generalised Barrett with a runtime modulus bit-length K. Full product feeds the reduction; no truncation. At most 2 corrections.
- Valid/ready streaming with tag sideband. Configuration (q, mu, K) is held in registers, so butterfly and pointwise-multiply datapaths stream operands only.

---
 rtl/mod_arith_pkg.sv | 15 +
 rtl/mod_mult_pipe_csub.sv | 12 +
 rtl/mod_mult_pipe.sv | 116 +++++++++++
 tb/tb_mod_mult_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared widths, latency and config types for the modular arithmetic units
package mod_arith_pkg;
  localparam int MM_W = 64;
  localparam int MM_TAG_W = 8;
  localparam int MOD_MULT_LAT = 4;
  localparam int MM_K_W = $clog2(MM_W) + 1;
  typedef logic [MM_W-1:0] word_t;
  typedef logic [MM_W:0] mu_t;
  typedef logic [MM_K_W-1:0] k_t;
  typedef struct packed {
    word_t q;
    mu_t   mu;
    k_t    k;
  } mm_cfg_t;
endpackage

// File: rtl/mod_mult_pipe_csub.sv
// mod_csub: conditional subtract, y = (x >= q) ? x - q : x
module mod_csub
  import mod_arith_pkg::*;
#(
  parameter int N = MM_W + 2
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_q,
  output logic [N-1:0] o_y
);
  assign o_y = (i_x >= i_q) ? i_x - i_q : i_x;
endmodule

// File: rtl/mod_mult_pipe.sv
// mod_mult_pipe: 4-stage Barrett modular multiplier (a*b) mod q with runtime K.
// Optional MOD_MULT_RANGE_CHECK_EN adds out_err for out-of-range operands/results.
module mod_mult_pipe
  import mod_arith_pkg::*;
#(
  parameter int W = MM_W,
  parameter int TAG_W = MM_TAG_W,
  parameter int LAT = MOD_MULT_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [W-1:0]       cfg_q,
  input  logic [W:0]         cfg_mu,
  input  logic [$clog2(W):0] cfg_k,
  output logic               cfg_err,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_res,
  output logic [TAG_W-1:0]   out_tag
`ifdef MOD_MULT_RANGE_CHECK_EN
  ,
  output logic               out_err
`endif
);
  localparam int KW = $clog2(W) + 1;
  localparam int ZW = 2 * W;
  localparam int TW = 2 * W + 2;
  localparam int RW = W + 2;
  if (LAT != MOD_MULT_LAT) begin : g_bad_lat
    $error("mod_mult_pipe supports only LAT = 4");
  end
  logic [W-1:0] r_q;
  logic [W:0] r_mu;
  logic [KW-1:0] r_k;
  logic r_v1, r_v2, r_v3;
  logic [ZW-1:0] r_z1, r_z2;
  logic [W:0] r_qe2;
  logic [RW-1:0] r_r3;
  logic [TAG_W-1:0] r_t1, r_t2, r_t3;
  logic w_en;
  logic [ZW-1:0] w_zs;
  logic [W:0] w_zlo;
  logic [TW-1:0] w_t, w_ts;
  logic [W:0] w_qe;
  logic [RW-1:0] w_r, w_r1, w_r2;
  assign w_en = !out_valid || out_ready;
  assign in_ready = w_en;
  assign busy = r_v1 || r_v2 || r_v3 || out_valid;
  // Barrett quotient estimate; in-contract operands keep z>>(K-1) and qe below 2^(K+1)
  assign w_zs = r_z1 >> (r_k - KW'(1));
  assign w_zlo = w_zs[W:0];
  assign w_t = TW'(w_zlo) * TW'(r_mu);
  assign w_ts = w_t >> (r_k + KW'(1));
  assign w_qe = w_ts[W:0];
  // true remainder is below 3q < 2^(W+2), so a W+2 bit wraparound subtract is exact
  assign w_r = RW'(r_z2) - RW'(r_qe2) * RW'(r_q);
  mod_csub #(.N(RW)) u_csub1 (.i_x(r_r3), .i_q(RW'(r_q)), .o_y(w_r1));
  mod_csub #(.N(RW)) u_csub2 (.i_x(w_r1), .i_q(RW'(r_q)), .o_y(w_r2));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      r_mu <= '0;
      r_k <= KW'(W);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (busy || in_valid);
      if (cfg_we && !busy && !in_valid) begin
        r_q <= cfg_q;
        r_mu <= cfg_mu;
        r_k <= cfg_k;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_v1, r_v2, r_v3, out_valid} <= '0;
      {r_z1, r_z2, r_qe2, r_r3} <= '0;
      {r_t1, r_t2, r_t3, out_tag} <= '0;
      out_res <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      out_valid <= r_v3;
      r_z1 <= ZW'(in_a) * ZW'(in_b);
      r_z2 <= r_z1;
      r_qe2 <= w_qe;
      r_r3 <= w_r;
      out_res <= W'(w_r2);
      r_t1 <= in_tag;
      r_t2 <= r_t1;
      r_t3 <= r_t2;
      out_tag <= r_t3;
    end
  end
`ifdef MOD_MULT_RANGE_CHECK_EN
  logic r_e1, r_e2, r_e3;
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_e1, r_e2, r_e3, out_err} <= '0;
    end else if (w_en) begin
      r_e1 <= (in_a >= r_q) || (in_b >= r_q);
      r_e2 <= r_e1;
      r_e3 <= r_e2;
      out_err <= r_e3 || (w_r2 >= RW'(r_q));
    end
  end
`endif
endmodule

// File: tb/tb_mod_mult_pipe.sv
// tb_mod_mult_pipe: directed and randomized checks of the Barrett modular multiplier pipeline
module tb_mod_mult_pipe;
  import mod_arith_pkg::*;
  localparam int W = 64;
  localparam int TW = 8;
  localparam int KW = 7;
  localparam int N_RND = 2500;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [W-1:0] cfg_q = '0;
  logic [W:0] cfg_mu = '0;
  logic [KW-1:0] cfg_k = '0;
  logic cfg_err, busy, in_ready, out_valid;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic [W-1:0] out_res;
  logic [TW-1:0] out_tag;
`ifdef MOD_MULT_RANGE_CHECK_EN
  logic out_err;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mod_mult_pipe #(.W(W), .TAG_W(TW), .LAT(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_k(cfg_k),
    .cfg_err(cfg_err), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag)
`ifdef MOD_MULT_RANGE_CHECK_EN
    , .out_err(out_err)
`endif
  );
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_mm(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return W'(p % {64'd0, q});
  endfunction
  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  task automatic set_cfg(input logic [W-1:0] q, input int k);
    logic [128:0] num;
    num = 129'd1 << (2 * k);
    cfg_q = q;
    cfg_k = KW'(k);
    cfg_mu = (W+1)'(num / {65'd0, q});
    cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
  endtask
  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                          input logic [W-1:0] exp, input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = t;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    while (!out_valid && n < 12) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, out_res, exp);
    chk({tag, "_tag"}, out_tag, t);
    cyc();
  endtask
  initial begin
    logic [W-1:0] gq;
    logic [W-1:0] q, mask;
    logic [W-1:0] exp_q[$];
    logic [TW-1:0] tag_q[$];
    int n, sent, got, cyc_n, ks[4];
    bit seen, acc;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    cyc();
    // q = 12289 streaming two items back to back
    set_cfg(64'd12289, 14);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 64'd5; in_b = 64'd7; in_tag = 8'd1;
    cyc();
    in_a = 64'd12288; in_b = 64'd12288; in_tag = 8'd2;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("lat_early", out_valid, 0);
    cyc();
    chk("lat_t4_valid", out_valid, 1);
    chk("lat_t4_res", out_res, 35);
    chk("lat_t4_tag", out_tag, 1);
    cyc();
    chk("lat_t5_valid", out_valid, 1);
    chk("lat_t5_res", out_res, 1);
    chk("lat_t5_tag", out_tag, 2);
    cyc();
    chk("drain_valid", out_valid, 0);
    chk("drain_busy", busy, 0);
    send_one(64'd0, 64'd9, 8'd3, 64'd0, "zero_a");
    // Goldilocks prime with K = W
    gq = 64'hFFFF_FFFF_0000_0001;
    set_cfg(gq, 64);
    send_one(64'h1_0000_0000, 64'h1_0000_0000, 8'd4, 64'hFFFF_FFFF, "gl_2p32");
    send_one(gq - 64'd1, gq - 64'd1, 8'd5, 64'd1, "gl_qm1");
    send_one(64'd0, gq - 64'd1, 8'd6, 64'd0, "gl_zero");
    // back-pressure: fill four items, stall six cycles, then drain
    set_cfg(64'd12289, 14);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 64'(i + 2); in_b = 64'(1000 + i); in_tag = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_full_valid", out_valid, 1);
    for (int j = 0; j < 6; j++) begin
      cyc();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_res", out_res, 64'd2000);
      chk("bp_hold_tag", out_tag, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rel_valid", out_valid, 1);
      chk("bp_rel_tag", out_tag, 128'(i));
      chk("bp_rel_res", out_res, 128'((i + 2) * (1000 + i)));
      cyc();
    end
    chk("bp_empty", out_valid, 0);
    // config write while busy is rejected and the old q stays in use
    in_valid = 1'b1; in_a = 64'd200; in_b = 64'd300; in_tag = 8'd7;
    cyc();
    in_valid = 1'b0;
    cfg_q = 64'd97; cfg_k = 7'd7; cfg_mu = 65'd168; cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    cyc();
    chk("cfg_err_clear", cfg_err, 0);
    n = 0;
    while (!out_valid && n < 12) begin
      cyc();
      n++;
    end
    chk("cfg_busy_res", out_res, 64'd10844);
    chk("cfg_busy_tag", out_tag, 7);
    cyc();
    set_cfg(64'd97, 7);
    chk("cfg_idle_err", cfg_err, 0);
    send_one(64'd50, 64'd60, 8'd8, 64'd90, "cfg_new_q");
    // reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 64'(i + 1); in_b = 64'd3; in_tag = 8'(20 + i);
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cyc();
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_stale", seen, 0);
    // randomized traffic over several modulus lengths
    ks = '{14, 32, 60, 64};
    foreach (ks[x]) begin
      mask = (64'd1 << ks[x]) - 64'd1;
      q = (rnd64() & mask) | (64'd1 << (ks[x] - 1));
      if (q == (64'd1 << (ks[x] - 1))) q = q + 64'd1;
      set_cfg(q, ks[x]);
      sent = 0; got = 0; cyc_n = 0;
      while (got < N_RND && cyc_n < N_RND * 20) begin
        out_ready = ($urandom_range(0, 9) < 7);
        if (!in_valid && sent < N_RND && $urandom_range(0, 9) < 7) begin
          in_a = rnd64() % q;
          in_b = rnd64() % q;
          in_tag = TW'(sent);
          in_valid = 1'b1;
        end
        #1;
        if (out_valid && out_ready) begin
          chk("rnd_expected_item", 128'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            chk("rnd_res", out_res, exp_q.pop_front());
            chk("rnd_tag", out_tag, tag_q.pop_front());
          end
          got++;
        end
        acc = in_valid && in_ready;
        if (acc) begin
          exp_q.push_back(ref_mm(in_a, in_b, q));
          tag_q.push_back(in_tag);
          sent++;
        end
        cyc();
        cyc_n++;
        if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      chk("rnd_count", 128'(got), 128'(N_RND));
      out_ready = 1'b1;
      for (int j = 0; j < 6; j++) cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
